// File: rtl/cmd_rx_pkg.sv
// Shared types and default constants for the serial command receiver.
package cmd_rx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  // 50 MHz / 19200 baud
  localparam int unsigned BAUD_DIV_DFLT = 2604;
  // About four byte times of idle line between the two bytes of a command
  localparam int unsigned TIMEOUT_DFLT  = 104160;

endpackage

// File: rtl/cmd_rx_uart_rx.sv
// 8N1 byte receiver: RX synchronizer, falling-edge detect and bit-sampling FSM.
module uart_rx
  import cmd_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       rx_idle
);

  localparam int unsigned CntW = $clog2(BAUD_DIV + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BAUD_DIV / 2);
  localparam logic [CntW-1:0] CntFull = CntW'(BAUD_DIV);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            rx_rdy_q, frm_err_q;
  logic            fall, expire;

  // Two-flop synchronizer plus a third flop for edge detection; presets match idle line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign fall   = rx_s3_q & ~rx_s2_q;
  // Counter is loaded with N and expires N clocks later
  assign expire = (cnt_q == CntOne);

  // Byte receiver FSM with registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            cnt_q   <= CntHalf;
          end
        end
        START: begin
          if (expire) begin
            // A high line at mid start bit was a glitch
            if (rx_s2_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              cnt_q   <= CntFull;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        DATA: begin
          if (expire) begin
            shift_q <= {rx_s2_q, shift_q[7:1]};
            cnt_q   <= CntFull;
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        STOP: begin
          if (expire) begin
            if (rx_s2_q) rx_rdy_q  <= 1'b1;
            else         frm_err_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = shift_q;
  assign rx_rdy  = rx_rdy_q;
  assign frm_err = frm_err_q;
  assign rx_idle = (state_q == IDLE);

endmodule

// File: rtl/cmd_rx_wrapper.sv
// Serial command receiver: assembles two UART bytes (high first) into a 16-bit command.
module cmd_rx_wrapper
  import cmd_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = BAUD_DIV_DFLT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

  logic [7:0]      rx_data;
  logic            rx_rdy, rx_ferr, rx_idle;
  asm_state_t      asm_q;
  logic [7:0]      hi_q;
  logic [15:0]     cmd_q;
  logic            rdy_q;
  logic [TmoW-1:0] tmo_q;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_rx (
    .clk    (clk),
    .rst    (rst),
    .RX     (RX),
    .rx_data(rx_data),
    .rx_rdy (rx_rdy),
    .frm_err(rx_ferr),
    .rx_idle(rx_idle)
  );

  // Assembly FSM with inter-byte timeout; a completion set overrides a same-clk clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= WAIT_HI;
      hi_q  <= '0;
      cmd_q <= '0;
      rdy_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      if (clr_cmd_rdy) rdy_q <= 1'b0;
      unique case (asm_q)
        WAIT_HI: begin
          if (rx_rdy) begin
            hi_q  <= rx_data;
            rdy_q <= 1'b0;
            tmo_q <= '0;
            asm_q <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (rx_rdy) begin
            cmd_q <= {hi_q, rx_data};
            rdy_q <= 1'b1;
            asm_q <= WAIT_HI;
          end else if (rx_ferr) begin
            asm_q <= WAIT_HI;
          end else if (rx_idle) begin
            // Idle time only; a start edge on the expiring clk becomes a new high byte
            if (tmo_q == TmoLast) asm_q <= WAIT_HI;
            else                  tmo_q <= tmo_q + TmoOne;
          end
        end
        default: asm_q <= WAIT_HI;
      endcase
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;
  assign frm_err = rx_ferr;

endmodule

// File: tb/tb_cmd_rx_wrapper.sv
// Self-checking bench for cmd_rx_wrapper with a transaction-level command model.
module tb_cmd_rx_wrapper;

  localparam int unsigned BaudDiv = 16;
  localparam int unsigned TmoCyc  = 640;

  logic        clk, rst, rx, clr;
  logic [15:0] cmd;
  logic        cmd_rdy, frm_err;

  cmd_rx_wrapper #(
    .BAUD_DIV   (BaudDiv),
    .TIMEOUT_CYC(TmoCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (rx),
    .clr_cmd_rdy(clr),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .frm_err    (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Output monitor, sampled on the falling edge
  int unsigned cyc = 0, ferr_cnt = 0, ferr_long = 0, rise_cnt = 0, rise_cyc = 0;
  logic        prev_ferr = 1'b0, prev_rdy = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frm_err) begin
      ferr_cnt <= ferr_cnt + 1;
      if (prev_ferr) ferr_long <= ferr_long + 1;
    end
    if (cmd_rdy && !prev_rdy) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    prev_ferr <= frm_err;
    prev_rdy  <= cmd_rdy;
  end

  // Reference model: command assembly at the byte-transaction level
  logic [15:0] m_cmd;
  logic        m_rdy, m_pend;
  logic [7:0]  m_hi;
  int unsigned m_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cmd  = 16'h0000;
    m_rdy  = 1'b0;
    m_pend = 1'b0;
    m_hi   = 8'h00;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_rdy = 1'b0;
    chk("clr_rdy", {31'd0, cmd_rdy}, {31'd0, m_rdy});
    chk("clr_cmd", {16'd0, cmd}, {16'd0, m_cmd});
  endtask

  // Send one frame after 'gap' idle clocks, update the model, then check outputs
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    int unsigned r0, st, lat;
    bit          done;
    rx = 1'b1;
    repeat (gap) tick();
    // Gaps are kept well away from the threshold; long gaps expire a pending high byte
    if (m_pend && gap >= int'(TmoCyc)) m_pend = 1'b0;
    r0 = rise_cnt;
    rx = 1'b0;
    st = cyc;
    repeat (BaudDiv) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BaudDiv) tick();
    end
    rx = stop_ok;
    repeat (BaudDiv) tick();
    rx = 1'b1;
    repeat (6) tick();
    done = 1'b0;
    if (!stop_ok) begin
      m_ferr++;
      m_pend = 1'b0;
    end else if (!m_pend) begin
      m_hi   = b;
      m_pend = 1'b1;
      m_rdy  = 1'b0;
    end else begin
      m_cmd  = {m_hi, b};
      m_rdy  = 1'b1;
      m_pend = 1'b0;
      done   = 1'b1;
    end
    chk("cmd", {16'd0, cmd}, {16'd0, m_cmd});
    chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, m_rdy});
    chk("frm_err_cnt", ferr_cnt, m_ferr);
    if (done) begin
      lat = rise_cyc - st;
      chk("rdy_rise", rise_cnt - r0, 1);
      chk("latency_window", {31'd0, (lat >= 150 && lat <= 160)}, 1);
    end
  endtask

  initial begin
    int unsigned r0, f0;
    logic [7:0]  b;
    rst = 1'b1;
    rx  = 1'b1;
    clr = 1'b0;
    m_ferr = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_cmd", {16'd0, cmd}, 0);
    chk("rst_rdy", {31'd0, cmd_rdy}, 0);
    chk("rst_ferr", {31'd0, frm_err}, 0);
    rst = 1'b0;
    repeat (5) tick();

    // 1: back-to-back A5, 3C; flag is sticky
    send_frame(8'hA5, 1'b1, 10);
    send_frame(8'h3C, 1'b1, 0);
    repeat (1000) tick();
    chk("sticky_rdy", {31'd0, cmd_rdy}, {31'd0, m_rdy});

    // 2: clear, then 55 55
    pulse_clr();
    send_frame(8'h55, 1'b1, 10);
    send_frame(8'h55, 1'b1, 5);

    // 3: bad stop on the low byte, then a clean command
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'h2D, 1'b0, 5);
    chk("ferr_single", ferr_long, 0);
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'h2D, 1'b1, 5);

    // 4: 3-clk glitch produces nothing
    r0 = rise_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (40) tick();
    chk("glitch_ferr", ferr_cnt, f0);
    chk("glitch_rise", rise_cnt, r0);
    chk("glitch_rdy", {31'd0, cmd_rdy}, {31'd0, m_rdy});
    send_frame(8'hAA, 1'b1, 10);
    send_frame(8'hAA, 1'b1, 5);

    // 5: stale high byte expires
    r0 = rise_cnt;
    send_frame(8'h12, 1'b1, 20);
    send_frame(8'hFF, 1'b1, 700);
    send_frame(8'hFF, 1'b1, 0);
    chk("tmo_one_rise", rise_cnt - r0, 1);

    // 6: reset during bit 4 of a high byte
    b  = 8'h1E;
    rx = 1'b0;
    repeat (BaudDiv) tick();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BaudDiv) tick();
    end
    rx = b[4];
    repeat (BaudDiv / 2) tick();
    rst = 1'b1;
    #1;
    chk("midrst_cmd", {16'd0, cmd}, 0);
    chk("midrst_rdy", {31'd0, cmd_rdy}, 0);
    chk("midrst_ferr", {31'd0, frm_err}, 0);
    rx = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    send_frame(8'h1E, 1'b1, 20);
    send_frame(8'h00, 1'b1, 5);

    // Randomized traffic: bad stops, clears and occasional timeouts
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(3) == 0) pulse_clr();
      b = 8'($urandom);
      send_frame(b, ($urandom_range(9) != 0),
                 ($urandom_range(4) == 0) ? int'($urandom_range(900, 700))
                                          : int'($urandom_range(300, 0)));
    end
    chk("ferr_single_all", ferr_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_rx_wrapper.md
Name: cmd_rx_wrapper

Overview:
- Receive end of the serial command link; CommMaster is the transmit end.
- Deserialises 8N1 UART frames on the RX line and assembles two consecutive bytes, high byte first, into a 16-bit travel-plan command word.
- Presents the word with a sticky `cmd_rdy` flag to the MazeRunner command processor.
- Sits between the RX input pin and the command-processing FSM inside MazeRunner.

Parameters:
- BAUD_DIV, 2604: clocks per bit (50 MHz / 19200 baud). Must be even and ≥ 8.
- TIMEOUT_CYC, 104160: max idle clocks allowed between the high-byte stop sample and the low-byte start edge (about 4 byte times).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- RX  input  1  serial line, idle high, asynchronous to clk
- clr_cmd_rdy  input  1  one-clk pulse from consumer that clears cmd_rdy
- cmd  output  16  last complete command word
- cmd_rdy  output  1  sticky: a new complete command is available
- frm_err  output  1  one-clk pulse on a bad stop bit

Behaviour:
- Reset: one clock, asynchronous active-high.
  - Sync flops preset to 1.
  - cmd = 16'h0000, cmd_rdy = 0, frm_err = 0, all counters 0.
  - Both FSMs go to their first state; assembly FSM to WAIT_HI.
- RX passes through a 2-flop synchronizer. Edge detection compares sync stage 2 against a third flop.
- Byte receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE: on a synced falling edge, go to START and load the baud counter with BAUD_DIV/2.
  - START: when the counter expires, sample RX.
    - If RX = 1 (glitch), return to IDLE with no output.
    - Otherwise go to DATA and reload the counter with BAUD_DIV.
  - DATA: sample 8 bits, LSB first, at each counter expiry into a shift register. Bit count is 0..7. After bit 7, go to STOP.
  - STOP: sample at counter expiry.
    - If 1, pulse rx_rdy for one clk with rx_data[7:0].
    - If 0, pulse frm_err for one clk and discard the byte.
    - Either way, go to IDLE. A new start edge is accepted from the next clk.
- Receiver latency: rx_rdy asserts 2 + BAUD_DIV/2 + 9·BAUD_DIV clks (±2) after the RX falling edge at the pin.
- Assembly FSM, states WAIT_HI, WAIT_LO:
  - WAIT_HI, on rx_rdy: latch hi_byte, clear cmd_rdy, clear the timeout counter, go to WAIT_LO.
  - WAIT_LO, on rx_rdy: register cmd ← {hi_byte, rx_data}, set cmd_rdy the next clk, go to WAIT_HI.
  - WAIT_LO, on frm_err: discard hi_byte and return to WAIT_HI. cmd and cmd_rdy are unchanged.
  - WAIT_LO timeout:
    - The timeout counter runs only while the receiver is in IDLE.
    - When it reaches TIMEOUT_CYC, discard hi_byte and return to WAIT_HI.
    - A start edge on the same clk as the timeout loses: the FSM still returns to WAIT_HI, and that byte is treated as a new high byte.
- cmd changes only on command completion; partial words are never visible.
- cmd_rdy is cleared by clr_cmd_rdy or by arrival of a new high byte. If clr_cmd_rdy and the completion set occur on the same clk, the set wins.
- frm_err in WAIT_HI: the pulse is still output; no state change.
- Reset mid-frame: all state is abandoned immediately. After release, the block resynchronises on the next falling edge and the partial frame is lost.
- A line held low (break): produces one frm_err, then the FSM waits in IDLE until RX returns high and falls again.

Decomposition:
- Shared package cmd_rx_pkg holds:
  - rx_state_t {IDLE, START, DATA, STOP}
  - asm_state_t {WAIT_HI, WAIT_LO}
  - default constants BAUD_DIV_DFLT, TIMEOUT_DFLT
- Sub-module uart_rx (synchronizer + byte receiver FSM) with ports clk, rst, RX, rx_data, rx_rdy, frm_err.
- cmd_rx_wrapper instantiates uart_rx and adds the assembly FSM, the timeout counter and the cmd/cmd_rdy registers.

Test Plan (bench overrides BAUD_DIV=16, TIMEOUT_CYC=640):
1. Bytes 0xA5 then 0x3C, back to back:
   - cmd = 16'hA53C and cmd_rdy = 1 within 2+8+144±2 clks of the second start edge.
   - cmd_rdy still 1 after 1000 further clks.
2. With cmd_rdy = 1, pulse clr_cmd_rdy:
   - cmd_rdy = 0 the next clk; cmd stays 16'hA53C.
   - Send 0x55, 0x55: cmd = 16'h5555.
3. High byte 0x00 good, low byte 0x2D with stop bit 0:
   - frm_err is a single 1-clk pulse; cmd_rdy stays 0; cmd unchanged.
   - Then send 0x00, 0x2D: cmd = 16'h002D.
4. RX driven low for 3 clks then high (glitch):
   - No rx_rdy, no frm_err, FSM stays in WAIT_HI.
   - Then send 0xAA, 0xAA: cmd = 16'hAAAA.
5. Send 0x12, then idle for 700 clks, then 0xFF, 0xFF:
   - The 0x12 is discarded by the timeout; cmd = 16'hFFFF.
   - Exactly one cmd_rdy rise.
6. Assert rst during bit 4 of a high byte:
   - cmd = 0, cmd_rdy = 0, frm_err = 0 immediately.
   - After release, send 0x1E, 0x00: cmd = 16'h1E00.
